// File: rtl/id_ex_pkg.sv
// id_ex_pkg: shared widths, ctrl bit indices, meta offsets and skid buffer states for the ID/EX register
package id_ex_pkg;
  localparam int XLEN_D = 32;
  localparam int REG_ADDR_W_D = 5;
  localparam int FUNCT_W_D = 10;
  localparam int ALUOP_W_D = 2;
  localparam int CTRL_W_D = 5 + ALUOP_W_D;
  localparam int REGWRITE = CTRL_W_D - 1;
  localparam int MEMTOREG = CTRL_W_D - 2;
  localparam int MEMREAD = CTRL_W_D - 3;
  localparam int MEMWRITE = CTRL_W_D - 4;
  localparam int ALUOP_MSB = ALUOP_W_D;
  localparam int ALUOP_LSB = 1;
  localparam int ALUSRC = 0;
  localparam int RD_LSB = 0;
  localparam int RS2_LSB = REG_ADDR_W_D;
  localparam int RS1_LSB = 2 * REG_ADDR_W_D;
  localparam int FUNCT_LSB = 3 * REG_ADDR_W_D;
  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} skid_state_t;
endpackage

// File: rtl/id_ex_pipe_reg_skid.sv
// pipe_skid_buf: valid/ready stage register with flush and optional two-entry skid buffer
module pipe_skid_buf
  import id_ex_pkg::*;
#(
  parameter int P = 128,
  parameter int SKID = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [P-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [P-1:0] out_data_o
);
  logic [P-1:0] m;
  logic m_valid;
  assign out_valid_o = m_valid;
  assign out_data_o = m;
  if (SKID != 0) begin : g_skid
    skid_state_t state;
    logic [P-1:0] s;
    logic ready;
    logic in_x, out_x;
    assign in_x = in_valid_i && ready;
    assign out_x = m_valid && out_ready_i;
    assign in_ready_o = ready;
    assign m_valid = state != ST_EMPTY;
    // main/skid storage; ready is its own flop so it never depends on out_ready_i
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        state <= ST_EMPTY;
        ready <= 1'b1;
        m <= '0;
        s <= '0;
      end else if (flush_i) begin
        state <= ST_EMPTY;
        ready <= 1'b1;
      end else begin
        case (state)
          ST_EMPTY: if (in_x) begin
            m <= in_data_i;
            state <= ST_FULL;
          end
          ST_FULL: if (in_x && out_x) m <= in_data_i;
          else if (in_x) begin
            s <= in_data_i;
            state <= ST_SKID;
            ready <= 1'b0;
          end else if (out_x) state <= ST_EMPTY;
          default: if (out_x) begin
            m <= s;
            state <= ST_FULL;
            ready <= 1'b1;
          end
        endcase
      end
    end
  end else begin : g_plain
    logic valid;
    assign m_valid = valid;
    assign in_ready_o = out_ready_i || !valid;
    // single register: load on accept, empty when drained without refill
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        valid <= 1'b0;
        m <= '0;
      end else if (flush_i) valid <= 1'b0;
      else if (in_valid_i && in_ready_o) begin
        m <= in_data_i;
        valid <= 1'b1;
      end else if (out_ready_i) valid <= 1'b0;
    end
  end
endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX stage register packing ctrl/data/meta and masking ctrl for bubbles
module id_ex_pipe_reg
  import id_ex_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int REG_ADDR_W = REG_ADDR_W_D,
  parameter int FUNCT_W = FUNCT_W_D,
  parameter int ALUOP_W = ALUOP_W_D,
  parameter int SKID = 1,
  localparam int CTRL_W = 5 + ALUOP_W,
  localparam int META_W = FUNCT_W + 3 * REG_ADDR_W,
  localparam int P = CTRL_W + 3 * XLEN + META_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [CTRL_W-1:0]   ctrl_i,
  input  logic [3*XLEN-1:0]   data_i,
  input  logic [META_W-1:0]   meta_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [CTRL_W-1:0]   ctrl_o,
  output logic [3*XLEN-1:0]   data_o,
  output logic [META_W-1:0]   meta_o
);
  logic [P-1:0] head;
  logic [CTRL_W-1:0] ctrl;
  pipe_skid_buf #(.P(P), .SKID(SKID)) u_buf (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .flush_i(flush_i),
    .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o),
    .in_data_i({ctrl_i, data_i, meta_i}),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o(head)
  );
  assign {ctrl, data_o, meta_o} = head;
  assign ctrl_o = out_valid_o ? ctrl : '0;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: scoreboard bench driving SKID=0 and SKID=1 instances with shared stimulus
module tb_id_ex_pipe_reg;
  typedef logic [127:0] word_t;
  logic clk = 0;
  logic rst = 0;
  logic flush = 0, in_valid = 0, out_ready = 0;
  logic [6:0] ctrl_in = '0;
  logic [95:0] data_in = '0;
  logic [24:0] meta_in = '0;
  logic [1:0] in_ready, out_valid;
  logic [6:0] ctrl_out [2];
  logic [95:0] data_out [2];
  logic [24:0] meta_out [2];
  word_t q [2][$];
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.SKID(0)) u0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready[0]),
    .ctrl_i(ctrl_in), .data_i(data_in), .meta_i(meta_in), .out_valid_o(out_valid[0]),
    .out_ready_i(out_ready), .ctrl_o(ctrl_out[0]), .data_o(data_out[0]), .meta_o(meta_out[0])
  );
  id_ex_pipe_reg #(.SKID(1)) u1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready[1]),
    .ctrl_i(ctrl_in), .data_i(data_in), .meta_i(meta_in), .out_valid_o(out_valid[1]),
    .out_ready_i(out_ready), .ctrl_o(ctrl_out[1]), .data_o(data_out[1]), .meta_o(meta_out[1])
  );

  task automatic cmp(input string name, input int k, input word_t act, input word_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s skid=%0d t=%0t got=%h expected=%h", name, k, $time, act, exp);
    end
  endtask

  function automatic word_t mk(input logic [4:0] rd);
    word_t w;
    w = {$urandom, $urandom, $urandom, $urandom};
    w[4:0] = rd;
    return w;
  endfunction

  task automatic step(input logic v, input logic f, input logic r, input word_t w);
    in_valid = v;
    flush = f;
    out_ready = r;
    {ctrl_in, data_in, meta_in} = w;
    @(posedge clk);
    #1;
  endtask

  // monitor: compare outputs with the FIFO model, then advance the model by this cycle's transfers
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic exp_ready, ox, ix;
      if (!rst) begin
        cmp("rst_valid", k, word_t'(out_valid[k]), 0);
        cmp("rst_ctrl", k, word_t'(ctrl_out[k]), 0);
        q[k].delete();
      end else begin
        exp_ready = k == 1 ? q[k].size() < 2 : (out_ready || q[k].size() == 0);
        cmp("in_ready", k, word_t'(in_ready[k]), word_t'(exp_ready));
        cmp("out_valid", k, word_t'(out_valid[k]), word_t'(q[k].size() != 0));
        if (!out_valid[k]) cmp("bubble_ctrl", k, word_t'(ctrl_out[k]), 0);
        else if (q[k].size() != 0) cmp("head", k, {ctrl_out[k], data_out[k], meta_out[k]}, q[k][0]);
        ox = q[k].size() != 0 && out_ready;
        ix = in_valid && exp_ready;
        if (ox) void'(q[k].pop_front());
        if (flush) q[k].delete();
        else if (ix) q[k].push_back({ctrl_in, data_in, meta_in});
      end
    end
  end

  initial begin
    word_t w;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    for (int i = 1; i <= 8; i++) step(1, 0, 1, mk(5'(i)));
    step(0, 0, 1, '0);
    step(1, 0, 0, mk(3));
    step(1, 0, 0, mk(4));
    repeat (3) step(1, 0, 0, mk(9));
    repeat (3) step(0, 0, 1, '0);
    w = mk(7);
    w[127:121] = 7'b1111111;
    step(1, 1, 1, w);
    repeat (3) step(0, 0, 1, '0);
    step(1, 0, 0, mk(10));
    step(1, 0, 0, mk(11));
    step(0, 1, 0, '0);
    repeat (3) step(0, 0, 1, '0);
    step(1, 0, 0, mk(12));
    #2 rst = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      cmp("async_rst_valid", k, word_t'(out_valid[k]), 0);
      cmp("async_rst_ctrl", k, word_t'(ctrl_out[k]), 0);
    end
    step(0, 0, 1, '0);
    rst = 1;
    step(1, 0, 1, mk(13));
    repeat (2) step(0, 0, 1, '0);
    for (int i = 0; i < 500; i++)
      step($urandom_range(3) != 0, $urandom_range(15) == 0, $urandom_range(2) != 0, mk(5'($urandom)));
    repeat (4) step(0, 0, 1, '0);
    for (int k = 0; k < 2; k++) cmp("drained", k, word_t'(q[k].size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
Parametrised ID/EX pipeline stage register with a valid/ready handshake. It adds stall by back-pressure, synchronous flush and bubble insertion, and an optional 2-entry skid buffer so that ready can be registered at full throughput. It sits between the decode stage (control unit, register file, immediate generator) and the execute stage (ALU, forwarding unit). Its forwarding fields (rs1/rs2/rd) feed the hazard and forwarding logic.

Parameters:
XLEN, 32, data path width (register read data, immediate)
REG_ADDR_W, 5, register index width (rs1, rs2, rd)
FUNCT_W, 10, width of the {funct7, funct3} field passed to ALU control
ALUOP_W, 2, ALUOp width
SKID, 1, 1 = two-entry skid buffer with registered in_ready_o; 0 = single register with combinational in_ready_o

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  asynchronous, active-low reset
flush_i  in  1  synchronous flush; discards all held entries and any same-cycle input
in_valid_i  in  1  decode stage presents a valid instruction
in_ready_o  out  1  stage can accept; transfer when in_valid_i && in_ready_o
ctrl_i  in  CTRL_W  packed {RegWrite, MemtoReg, MemRead, MemWrite, ALUOp, ALUSrc}
data_i  in  3*XLEN  packed {rs1_data, rs2_data, imm}
meta_i  in  FUNCT_W+3*REG_ADDR_W  packed {funct, rs1, rs2, rd}
out_valid_o  out  1  execute-stage entry valid
out_ready_i  in  1  execute stage consumes; transfer when out_valid_o && out_ready_i
ctrl_o  out  CTRL_W  control of the head entry; all-zero when out_valid_o=0
data_o  out  3*XLEN  data of the head entry
meta_o  out  FUNCT_W+3*REG_ADDR_W  funct/rs1/rs2/rd of the head entry

Behaviour:
- CTRL_W = 5 + ALUOP_W. Payload P = CTRL_W + 3*XLEN + FUNCT_W + 3*REG_ADDR_W (128 at defaults).
- Reset (rst_i=0, asynchronous):
  - out_valid_o=0; all payload registers 0; skid entry empty.
  - in_ready_o=1 once reset is released. For SKID=1 it is already 1 during reset.
- Latency: a word accepted at edge N appears on the outputs with out_valid_o=1 after edge N. One cycle, no combinational in->out path.
- Bubble: ctrl_o is forced to 0 whenever out_valid_o=0, so RegWrite, MemRead and MemWrite can never fire for a bubble. data_o and meta_o keep their last value while invalid.
- SKID=0:
  - in_ready_o = out_ready_i || !out_valid_o (combinational).
  - The register loads on an input transfer.
  - out_valid_o clears on an output transfer with no simultaneous input.
- SKID=1 state machine, with main register M and skid register S:
  - EMPTY: in_ready=1. Input -> FULL.
  - FULL (M valid): in_ready=1.
    - Input and output together -> FULL, M takes the new word.
    - Input only -> SKID, new word into S.
    - Output only -> EMPTY.
  - SKID (M and S valid): in_ready=0.
    - Output -> FULL, with M <= S.
  - in_ready_o = !S_valid, driven directly from a flop.
- Ordering is strict FIFO: no drop, no duplication, no reorder.
- Flush:
  - At the next edge M_valid=0 and S_valid=0, and the state becomes EMPTY.
  - An input transfer in the same cycle is discarded.
  - An output transfer in the same cycle is still considered consumed.
  - Flush has priority over every other event.
- Stall: out_ready_i=0 holds M unchanged indefinitely. The head payload stays stable while out_valid_o=1 && out_ready_i=0.
- Reset mid-operation: all entries are lost immediately and the outputs return to reset values asynchronously.

Decomposition:
- Package id_ex_pkg holds:
  - ctrl bit indices: REGWRITE=CTRL_W-1, MEMTOREG=CTRL_W-2, MEMREAD=CTRL_W-3, MEMWRITE=CTRL_W-4, ALUOP=[ALUOP_W:1], ALUSRC=0;
  - meta slice offsets;
  - default widths.
- Sub-module pipe_skid_buf (parameters P, SKID) implements the handshake, flush and storage for a generic payload.
- id_ex_pipe_reg packs and unpacks the fields and applies the ctrl_o bubble mask.

Test Plan:
- Reset, then stream 8 words with out_ready_i=1 and in_valid_i=1 every cycle (rd=1..8) -> out_valid_o from cycle 1, rd_o=1..8 in order, in_ready_o constantly 1 (both SKID values).
- SKID=1: accept rd=3 and rd=4, hold out_ready_i=0 -> in_ready_o=0 after the second word; release -> rd_o=3 then 4; in_ready_o=1 again one cycle after the first output transfer.
- Inject ctrl_i=7'b1111111 and assert flush_i the same cycle -> next cycle out_valid_o=0 and ctrl_o=0; no word appears later.
- SKID state with flush_i=1 and out_ready_i=0 -> both entries dropped, in_ready_o=1 next cycle, no stale rd on any later output.
- Drop rst_i asynchronously between edges while FULL -> out_valid_o=0 and ctrl_o=0 immediately; first word after release arrives with 1-cycle latency.
- Random in_valid_i/out_ready_i/flush_i with SKID=0 and SKID=1 against a FIFO scoreboard -> no loss or duplication outside flushes, and ctrl_o==0 whenever out_valid_o=0.
